// File: rtl/multiplier_iterative_param.sv
// multiplier_iterative_param: multi-cycle shift-and-add multiplier, DIGIT multiplier bits per clock.
// Define MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are all zero.
module multiplier_iterative_param #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_in,
   output logic               ready_in,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               valid_out,
   output logic [2*WIDTH-1:0] r,
   output logic               busy
);
   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW = $clog2(STEPS + 1);

   generate
      if (!((DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8) && (WIDTH % DIGIT == 0))) begin : g_bad
         $error("multiplier_iterative_param: illegal WIDTH/DIGIT combination");
      end
   endgenerate

   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_next;

   logic [WIDTH-1:0]   mp, abs_a, abs_b;
   logic [2*WIDTH-1:0] mc, acc, acc_next;
   logic [CW-1:0]      cnt;
   logic               neg, accept, done;

   assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;
   assign accept = valid_in && ready_in;
   assign acc_next = acc + {{(2*WIDTH-DIGIT){1'b0}}, mp[DIGIT-1:0]} * mc;

`ifdef MULT_EARLY_TERM_EN
   assign done = (cnt == CW'(STEPS - 1)) || ((mp >> DIGIT) == '0);
`else
   assign done = cnt == CW'(STEPS - 1);
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_next;

   always_comb begin
      state_next = state;
      if (state == IDLE) state_next = accept ? RUN : IDLE;
      else state_next = done ? IDLE : RUN;
   end

   always_comb begin
      ready_in = state == IDLE;
      busy = state == RUN;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         mp <= '0;
         mc <= '0;
         acc <= '0;
         cnt <= '0;
         neg <= 1'b0;
         r <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (accept) begin
            neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            mc <= {{WIDTH{1'b0}}, abs_a};
            mp <= abs_b;
            acc <= '0;
            cnt <= '0;
         end else if (state == RUN) begin
            acc <= acc_next;
            mp <= mp >> DIGIT;
            mc <= mc << DIGIT;
            cnt <= cnt + CW'(1);
            if (done) begin
               r <= neg ? -acc_next : acc_next;
               valid_out <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_multiplier_iterative_param.sv
// tb_multiplier_iterative_param: scoreboard bench for the iterative multiplier, 32/4 and 16/2 builds.
module tb_multiplier_iterative_param;
   typedef struct {
      logic [63:0] r;
      int          due;
   } exp_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        v0 = 1'b0, s0 = 1'b0, rdy0, vo0, busy0;
   logic [31:0] a0 = '0, b0 = '0;
   logic [63:0] r0;
   logic        v1 = 1'b0, s1 = 1'b0, rdy1, vo1, busy1;
   logic [15:0] a1 = '0, b1 = '0;
   logic [31:0] r1;
   exp_t        q0[$], q1[$];
   int          cyc = 0, checks = 0, fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multiplier_iterative_param #(.WIDTH(32), .DIGIT(4)) u0 (
      .clk(clk), .rst(rst), .valid_in(v0), .ready_in(rdy0), .is_signed(s0),
      .a(a0), .b(b0), .valid_out(vo0), .r(r0), .busy(busy0));

   multiplier_iterative_param #(.WIDTH(16), .DIGIT(2)) u1 (
      .clk(clk), .rst(rst), .valid_in(v1), .ready_in(rdy1), .is_signed(s1),
      .a(a1), .b(b1), .valid_out(vo1), .r(r1), .busy(busy1));

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Expected edges from accept to valid_out for this build.
   function automatic int lat(input int d, input logic s, input logic [31:0] y);
      int w, dg, n;
      logic [31:0] m;
      w = d ? 16 : 32;
      dg = d ? 2 : 4;
      n = w / dg;
`ifdef MULT_EARLY_TERM_EN
      m = d ? {16'b0, y[15:0]} : y;
      if (s && m[w-1]) m = d ? {16'b0, -m[15:0]} : -m;
      n = 0;
      while (m != 0) begin
         n++;
         m = m >> dg;
      end
      if (n == 0) n = 1;
`endif
      return n;
   endfunction

   task automatic issue(input int d, input logic s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] e);
      int n;
      logic took;
      exp_t t;
      @(negedge clk);
      if (d == 0) begin s0 = s; a0 = x; b0 = y; v0 = 1'b1; end
      else begin s1 = s; a1 = x[15:0]; b1 = y[15:0]; v1 = 1'b1; end
      took = 1'b0;
      n = 0;
      while (!took && n < 100) begin
         took = d ? rdy1 : rdy0;
         @(posedge clk);
         #1;
         if (!took) @(negedge clk);
         n++;
      end
      if (!took) begin
         checks++;
         fails++;
         $display("FAIL accept_timeout dut%0d: got no accept expected accept within 100 cycles", d);
      end else begin
         t.r = e;
         t.due = cyc + lat(d, s, y);
         if (d == 0) q0.push_back(t);
         else q1.push_back(t);
      end
      if (d == 0) v0 = 1'b0;
      else v1 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         checks++;
         fails++;
         $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      end
      @(negedge clk);
   endtask

   always @(negedge clk)
      if (!rst && vo0) begin
         if (q0.size() == 0) chk("dut0_spurious_valid_out", 64'd1, 64'd0);
         else begin
            exp_t t;
            t = q0.pop_front();
            chk("dut0_r", r0, t.r);
            chk("dut0_latency", 64'(cyc), 64'(t.due));
         end
      end

   always @(negedge clk)
      if (!rst && vo1) begin
         if (q1.size() == 0) chk("dut1_spurious_valid_out", 64'd1, 64'd0);
         else begin
            exp_t t;
            t = q1.pop_front();
            chk("dut1_r", {32'b0, r1}, t.r);
            chk("dut1_latency", 64'(cyc), 64'(t.due));
         end
      end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_ready", 64'(rdy0), 64'd1);
      chk("reset_busy", 64'(busy0), 64'd0);
      chk("reset_valid_out", 64'(vo0), 64'd0);
      chk("reset_r", r0, 64'd0);
      rst = 1'b0;

      issue(0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
      chk("run_ready_low", 64'(rdy0), 64'd0);
      chk("run_busy_high", 64'(busy0), 64'd1);
      issue(0, 1'b1, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB);
      issue(0, 1'b0, 32'hFFFFFFFD, 32'd7, 64'h00000006FFFFFFEB);
      issue(0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
      issue(0, 1'b1, 32'h80000000, 32'd1, 64'hFFFFFFFF80000000);
      issue(0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1);

      // Operands change and valid_in stays high while busy; the second op lands on the valid_out cycle.
      issue(0, 1'b0, 32'd7, 32'd9, 64'd63);
      a0 = 32'd5; b0 = 32'd5; v0 = 1'b1;
      issue(0, 1'b0, 32'd5, 32'd5, 64'd25);
      drain();

      @(negedge clk);
      s0 = 1'b0; a0 = 32'd9; b0 = 32'd9; v0 = 1'b1;
      @(posedge clk);
      #1 v0 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async_reset_ready", 64'(rdy0), 64'd1);
      chk("async_reset_busy", 64'(busy0), 64'd0);
      chk("async_reset_r", r0, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("after_abort_r", r0, 64'd0);
      issue(0, 1'b0, 32'd3, 32'd4, 64'd12);

      issue(0, 1'b0, 32'h1234, 32'd0, 64'd0);
      issue(0, 1'b0, 32'd2, 32'h10, 64'h20);
      issue(1, 1'b0, 32'hFFFF, 32'hFFFF, 64'hFFFE0001);
      issue(1, 1'b1, 32'hFFFE, 32'd3, 64'hFFFFFFFA);
      issue(1, 1'b1, 32'h8000, 32'h8000, 64'h40000000);
      drain();
      repeat (3) @(negedge clk);
      chk("held_r", r0, 64'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
